// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states, counter sizing.
package md_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } md_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/md_addsub.sv
// Shared adder/subtractor; co is the carry out (for subtract: 1 means x >= y, no borrow).
module md_addsub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] yy;

  assign yy      = sub ? ~y : y;
  assign {co, s} = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/md_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MD_EARLY_OUT_EN: multiply CALC stops once the remaining multiplier bits are zero.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  md_state_e          state;
  logic               fix_ph;
  logic               div_q;
  logic               sa, sb;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   mreg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     ax, ay, as;
  logic               asub, aco;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] aligned;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH-1:0]   rem_fix, quo_fix;
  logic               early_exit;

  assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

  // Divide: trial-subtract divisor from {rem, next dividend bit}.
  // Multiply: conditionally add multiplicand to the high half.
  always_comb begin
    ax   = '0;
    ay   = '0;
    asub = 1'b0;
    if (div_q) begin
      ax   = acc[2*WIDTH-2:WIDTH-1];
      ay   = {1'b0, opnd};
      asub = 1'b1;
    end else begin
      ax   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      ay   = mreg[0] ? {1'b0, opnd} : '0;
      asub = 1'b0;
    end
  end

  md_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
    .x   (ax),
    .y   (ay),
    .sub (asub),
    .s   (as),
    .co  (aco)
  );

  always_comb begin
    acc_step = '0;
    if (div_q)
      acc_step = aco ? {as[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = {as, acc[WIDTH-1:1]};
  end

`ifdef MD_EARLY_OUT_EN
  logic [CW-1:0] shamt;
  assign early_exit = !div_q && (mreg == '0);
  // Skipped iterations would only have shifted right; apply them all at once.
  assign shamt      = CW'(WIDTH) - cnt;
  assign aligned    = acc >> shamt;
`else
  assign early_exit = 1'b0;
  assign aligned    = acc;
`endif

  always_comb begin
    rem_fix = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    quo_fix = (opnd == '0) ? '1 : ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    fixed   = div_q ? {rem_fix, quo_fix} : ((sa ^ sb) ? -aligned : aligned);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      fix_ph <= 1'b0;
      div_q  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      mreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mthi) hi <= a;
          if (mtlo) lo <= a;
          if (start) begin
            div_q  <= op[1];
            sa     <= op[0] & a[WIDTH-1];
            sb     <= op[0] & b[WIDTH-1];
            cnt    <= '0;
            fix_ph <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_CALC;
            if (op[1]) begin
              opnd <= abs_b;
              mreg <= '0;
              acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              mreg <= abs_b;
              acc  <= '0;
            end
          end
        end
        ST_CALC: begin
          if (early_exit) begin
            state <= ST_FIX;
          end else begin
            acc  <= acc_step;
            mreg <= mreg >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // Sign fix-up is registered first; HI/LO commit on the following edge.
          if (!fix_ph) begin
            acc    <= fixed;
            fix_ph <= 1'b1;
          end else begin
            hi    <= acc[2*WIDTH-1:WIDTH];
            lo    <= acc[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed + randomized bench for md_sequencer against a 64-bit arithmetic reference model.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests;
  int fails;

  md_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      OP_MULTU: p = {32'h0, x} * {32'h0, y};
      OP_MULT:  p = sx * sy;
      OP_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input bit inject, input bit mt, output int lat);
    logic [63:0] e;
    bit busy_ok;
    e = ref_md(o, xa, xb);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb; mthi = mt;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    if (mt) check("mthi_with_start", {32'h0, hi}, {32'h0, xa});
    a = $urandom; b = $urandom;
    busy_ok = (busy === 1'b1);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (inject && c == 10) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = OP_MULTU;
      end
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("busy_held", {63'h0, busy_ok}, 64'h1);
    check("done_seen", {63'h0, (lat != 0)}, 64'h1);
    check("busy_low_at_done", {63'h0, busy}, 64'h0);
    check("result", {hi, lo}, e);
`ifdef MD_EARLY_OUT_EN
    if (o[1]) check("latency_div", 64'(lat), 64'd34);
    else      check("latency_mul_bound", {63'h0, (lat <= 34)}, 64'h1);
`else
    check("latency", 64'(lat), 64'd34);
`endif
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, 30'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Moves to HI/LO while idle
    @(negedge clk); mthi = 1'b1; a = 32'h1234_5678;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; a = 32'h9ABC_DEF0;
    @(negedge clk); mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, lat);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 0, 0, lat);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, lat);
    run_op(OP_DIVU,  32'd100, 32'd7, 0, 0, lat);
    run_op(OP_DIVU,  32'd9, 32'd0, 0, 0, lat);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0, 0, 0, lat);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, lat);
    run_op(OP_DIVU,  32'hDEAD_BEEF, 32'h0000_1234, 1, 0, lat);
    run_op(OP_MULTU, 32'h0BAD_F00D, 32'h1357_9BDF, 0, 1, lat);

    run_op(OP_MULTU, 32'd5, 32'd1, 0, 0, lat);
`ifdef MD_EARLY_OUT_EN
    check("early_out_faster", {63'h0, (lat < 34)}, 64'h1);
`endif
    run_op(OP_MULTU, 32'h0000_00FF, 32'd0, 0, 0, lat);

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'h7777_7777; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("midop_reset_busy_done", {62'h0, busy, done}, 64'h0);
    check("midop_reset_hilo", {hi, lo}, 64'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_reset", {63'h0, saw_done}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd7, 0, 0, lat);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       ra = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if (rb === 32'hx) rb = $urandom;
      run_op(ro, ra, rb, (i % 7) == 3, (i % 5) == 2, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
